// File: rtl/memory_stage.sv
// MEM pipeline stage: drives loads/stores onto a valid/ready data-memory bus,
// steers byte lanes, extends load data and registers the MEM/WB payload.
package memory_stage_pkg;
    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic [2:0]  funct3;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  rd_addr;
        logic [31:0] pc_plus_4;
    } ex_mem_data_t;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  rd_addr;
        logic [31:0] pc_plus_4;
    } mem_wb_data_t;
endpackage

// state    | meaning
// IDLE     | no bus transaction; issue aligned mem ops, pass others through
// REQ      | request presented, waiting for ready
// WAIT_RSP | request accepted, waiting for response or timeout
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  ex_mem_data_t          ex_mem_data_i,
    output logic                  stall_o,
    output logic                  dmem_req_valid_o,
    input  logic                  dmem_req_ready_i,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic                  dmem_rsp_valid_i,
    input  logic [31:0]           dmem_rdata_i,
    output mem_wb_data_t          mem_wb_data_o,
    output logic                  misalign_o,
    output logic                  bus_error_o
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_misalign;
    logic             r_bus_error;
    mem_wb_data_t     r_mem_wb;
    mem_wb_data_t     w_mem_wb_nxt;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_issue;
    logic [1:0]  w_a;
    logic [2:0]  w_f3;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_req_valid;
    logic        w_stall;
    logic        w_rsp_take;
    logic        w_timeout;

    assign w_a          = ex_mem_data_i.alu_result[1:0];
    assign w_f3         = ex_mem_data_i.funct3;
    assign w_is_load    = valid_i && (ex_mem_data_i.result_src == RESULT_SRC_MEM);
    assign w_is_store   = valid_i && ex_mem_data_i.mem_write;
    assign w_mem_op     = w_is_load || w_is_store;
    // funct3[1] set covers word (and the unused 3'bx11 encodings, treated as word)
    assign w_misaligned = ((w_f3[1:0] == 2'b01) && w_a[0]) || (w_f3[1] && (w_a != 2'b00));
    assign w_issue      = w_mem_op && !w_misaligned;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_mem_data_i.write_data;
        if (!w_is_load) begin
            case (w_f3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_a;
                    w_wdata = {4{ex_mem_data_i.write_data[7:0]}};
                end
                2'b01: begin
                    w_be    = w_a[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{ex_mem_data_i.write_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = ex_mem_data_i.write_data;
                end
            endcase
        end
    end

    assign w_byte = dmem_rdata_i[{w_a, 3'b000} +: 8];
    assign w_half = dmem_rdata_i[{w_a[1], 4'b0000} +: 16];

    always_comb begin
        case (w_f3[1:0])
            2'b00:   w_load_data = w_f3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = w_f3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_stall     = 1'b0;
        w_rsp_take  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_req_valid = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = dmem_req_ready_i ? WAIT_RSP : REQ;
                end
            end
            REQ: begin
                w_req_valid = 1'b1;
                w_stall     = 1'b1;
                if (dmem_req_ready_i) w_state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid_i) begin
                    w_rsp_take  = 1'b1;
                    w_state_nxt = IDLE;
                end else if ((MAX_WAIT != 0) && (r_wait_cnt == CNT_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // EX/MEM is held while stalled, so the live payload is still on ex_mem_data_i at completion
    always_comb begin
        w_mem_wb_nxt = '0;
        if (!w_stall && (valid_i || r_state == WAIT_RSP)) begin
            w_mem_wb_nxt.result_src = ex_mem_data_i.result_src;
            w_mem_wb_nxt.alu_result = ex_mem_data_i.alu_result;
            w_mem_wb_nxt.rd_addr    = ex_mem_data_i.rd_addr;
            w_mem_wb_nxt.pc_plus_4  = ex_mem_data_i.pc_plus_4;
            if (r_state == WAIT_RSP) begin
                w_mem_wb_nxt.reg_write = w_rsp_take && ex_mem_data_i.reg_write;
                w_mem_wb_nxt.read_data = (w_rsp_take && w_is_load) ? w_load_data : 32'd0;
            end else begin
                w_mem_wb_nxt.reg_write = ex_mem_data_i.reg_write && !(w_mem_op && w_misaligned);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_mem_wb    <= '0;
            r_misalign  <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_wb    <= w_mem_wb_nxt;
            r_misalign  <= (r_state == IDLE) && w_mem_op && w_misaligned;
            r_bus_error <= w_timeout;
            if ((r_state == WAIT_RSP) && (w_state_nxt == WAIT_RSP) && (MAX_WAIT != 0))
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
        end
    end

    assign stall_o          = w_stall && !rst;
    assign dmem_req_valid_o = w_req_valid && !rst;
    assign dmem_we_o        = w_is_store;
    assign dmem_addr_o      = {ex_mem_data_i.alu_result[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_be_o        = w_be;
    assign dmem_wdata_o     = w_wdata;
    assign mem_wb_data_o    = r_mem_wb;
    assign misalign_o       = r_misalign;
    assign bus_error_o      = r_bus_error;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: scoreboard of expected MEM/WB payloads plus
// cycle-level checks of bus handshake, stall, misalign and timeout behaviour.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    ex_mem_data_t ex_mem_data_i;
    logic         stall_o;
    logic         dmem_req_valid_o;
    logic         dmem_req_ready_i;
    logic         dmem_we_o;
    logic [31:0]  dmem_addr_o;
    logic [3:0]   dmem_be_o;
    logic [31:0]  dmem_wdata_o;
    logic         dmem_rsp_valid_i;
    logic [31:0]  dmem_rdata_i;
    mem_wb_data_t mem_wb_data_o;
    logic         misalign_o;
    logic         bus_error_o;

    int checks   = 0;
    int failures = 0;
    mem_wb_data_t q[$];

    memory_stage #(.ADDR_WIDTH(32), .MAX_WAIT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .ex_mem_data_i    (ex_mem_data_i),
        .stall_o          (stall_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .mem_wb_data_o    (mem_wb_data_o),
        .misalign_o       (misalign_o),
        .bus_error_o      (bus_error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag);
        mem_wb_data_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=%0h", tag, mem_wb_data_o);
        end else begin
            e = q.pop_front();
            chk(tag, 128'(mem_wb_data_o), 128'(e));
        end
    endtask

    function automatic ex_mem_data_t mk(input logic rw, input logic [1:0] src, input logic mw,
                                        input logic [2:0] f3, input logic [31:0] alu,
                                        input logic [31:0] wd, input logic [4:0] rd,
                                        input logic [31:0] pc);
        ex_mem_data_t d;
        d.reg_write  = rw;
        d.result_src = src;
        d.mem_write  = mw;
        d.funct3     = f3;
        d.alu_result = alu;
        d.write_data = wd;
        d.rd_addr    = rd;
        d.pc_plus_4  = pc;
        return d;
    endfunction

    function automatic mem_wb_data_t wb(input logic rw, input logic [1:0] src, input logic [31:0] rdat,
                                        input logic [31:0] alu, input logic [4:0] rd,
                                        input logic [31:0] pc);
        mem_wb_data_t d;
        d.reg_write  = rw;
        d.result_src = src;
        d.read_data  = rdat;
        d.alu_result = alu;
        d.rd_addr    = rd;
        d.pc_plus_4  = pc;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load with ready=1 in the issue cycle and the response on the following cycle
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_rd);
        ex_mem_data_i    = mk(1'b1, RESULT_SRC_MEM, 1'b0, f3, addr, 32'hDEAD_BEEF, 5'd9, 32'h2000);
        valid_i          = 1'b1;
        dmem_req_ready_i = 1'b1;
        q.push_back(wb(1'b1, RESULT_SRC_MEM, exp_rd, addr, 5'd9, 32'h2000));
        @(negedge clk);
        chk({tag, "_req"},   128'(dmem_req_valid_o), 128'(1'b1));
        chk({tag, "_stall"}, 128'(stall_o), 128'(1'b1));
        chk({tag, "_addr"},  128'(dmem_addr_o), 128'({addr[31:2], 2'b00}));
        chk({tag, "_be"},    128'(dmem_be_o), 128'(4'b1111));
        chk({tag, "_we"},    128'(dmem_we_o), 128'(1'b0));
        step();
        dmem_req_ready_i = 1'b0;
        chk({tag, "_bubble"}, 128'(mem_wb_data_o), 128'(0));
        dmem_rsp_valid_i = 1'b1;
        dmem_rdata_i     = rdata;
        @(negedge clk);
        chk({tag, "_rsp_stall"}, 128'(stall_o), 128'(1'b0));
        chk({tag, "_rsp_req"},   128'(dmem_req_valid_o), 128'(1'b0));
        step();
        dmem_rsp_valid_i = 1'b0;
        valid_i          = 1'b0;
        check_wb({tag, "_wb"});
    endtask

    initial begin
        int n;
        rst              = 1'b1;
        valid_i          = 1'b1;
        ex_mem_data_i    = mk(1'b1, RESULT_SRC_MEM, 1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 32'h4);
        dmem_req_ready_i = 1'b1;
        dmem_rsp_valid_i = 1'b0;
        dmem_rdata_i     = 32'h0;

        // Reset holds everything quiet even with a live load presented
        #2;
        chk("rst_stall",  128'(stall_o), 128'(1'b0));
        chk("rst_req",    128'(dmem_req_valid_o), 128'(1'b0));
        chk("rst_wb",     128'(mem_wb_data_o), 128'(0));
        chk("rst_mis",    128'(misalign_o), 128'(1'b0));
        chk("rst_buserr", 128'(bus_error_o), 128'(1'b0));
        valid_i          = 1'b0;
        dmem_req_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        // ALU op passes straight through with no stall
        ex_mem_data_i = mk(1'b1, RESULT_SRC_ALU, 1'b0, 3'b000, 32'h40, 32'h0, 5'd5, 32'h1004);
        valid_i       = 1'b1;
        q.push_back(wb(1'b1, RESULT_SRC_ALU, 32'h0, 32'h40, 5'd5, 32'h1004));
        @(negedge clk);
        chk("add_stall", 128'(stall_o), 128'(1'b0));
        chk("add_req",   128'(dmem_req_valid_o), 128'(1'b0));
        step();
        valid_i = 1'b0;
        check_wb("add_wb");

        do_load("lb",  3'b000, 32'h103, 32'h80FF_FF7F, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h101, 32'h80FF_FF7F, 32'h0000_00FF);
        do_load("lh",  3'b001, 32'h100, 32'h80FF_FF7F, 32'hFFFF_FF7F);
        do_load("lhu", 3'b101, 32'h102, 32'h80FF_FF7F, 32'h0000_80FF);
        do_load("lw",  3'b010, 32'h104, 32'h80FF_FF7F, 32'h80FF_FF7F);

        // SH with ready withheld three cycles: request must hold steady
        ex_mem_data_i    = mk(1'b0, RESULT_SRC_ALU, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 5'd0, 32'h3000);
        valid_i          = 1'b1;
        dmem_req_ready_i = 1'b0;
        q.push_back(wb(1'b0, RESULT_SRC_ALU, 32'h0, 32'h102, 5'd0, 32'h3000));
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) dmem_req_ready_i = 1'b1;
            @(negedge clk);
            if (stall_o) n++;
            chk("sh_req",   128'(dmem_req_valid_o), 128'(1'b1));
            chk("sh_we",    128'(dmem_we_o), 128'(1'b1));
            chk("sh_addr",  128'(dmem_addr_o), 128'(32'h100));
            chk("sh_be",    128'(dmem_be_o), 128'(4'b1100));
            chk("sh_wdata", 128'(dmem_wdata_o), 128'(32'hABCD_ABCD));
            step();
        end
        dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b1;
        @(negedge clk);
        if (stall_o) n++;
        chk("sh_rsp_req", 128'(dmem_req_valid_o), 128'(1'b0));
        step();
        dmem_rsp_valid_i = 1'b0;
        valid_i          = 1'b0;
        chk("sh_stall_cycles", 128'(n), 128'(4));
        check_wb("sh_wb");

        // SB lane steering
        ex_mem_data_i    = mk(1'b0, RESULT_SRC_ALU, 1'b1, 3'b000, 32'h101, 32'h1234_ABCD, 5'd0, 32'h3004);
        valid_i          = 1'b1;
        dmem_req_ready_i = 1'b1;
        q.push_back(wb(1'b0, RESULT_SRC_ALU, 32'h0, 32'h101, 5'd0, 32'h3004));
        @(negedge clk);
        chk("sb_be",    128'(dmem_be_o), 128'(4'b0010));
        chk("sb_wdata", 128'(dmem_wdata_o), 128'(32'hCDCD_CDCD));
        step();
        dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b1;
        step();
        dmem_rsp_valid_i = 1'b0;
        valid_i          = 1'b0;
        check_wb("sb_wb");

        // Misaligned LW is dropped without a bus request
        ex_mem_data_i = mk(1'b1, RESULT_SRC_MEM, 1'b0, 3'b010, 32'h06, 32'h0, 5'd3, 32'h4000);
        valid_i       = 1'b1;
        q.push_back(wb(1'b0, RESULT_SRC_MEM, 32'h0, 32'h06, 5'd3, 32'h4000));
        @(negedge clk);
        chk("mis_req",   128'(dmem_req_valid_o), 128'(1'b0));
        chk("mis_stall", 128'(stall_o), 128'(1'b0));
        step();
        valid_i = 1'b0;
        chk("mis_pulse", 128'(misalign_o), 128'(1'b1));
        check_wb("mis_wb");
        step();
        chk("mis_pulse_end", 128'(misalign_o), 128'(1'b0));

        // Timeout: accepted LW with no response
        ex_mem_data_i    = mk(1'b1, RESULT_SRC_MEM, 1'b0, 3'b010, 32'h200, 32'h0, 5'd4, 32'h5000);
        valid_i          = 1'b1;
        dmem_req_ready_i = 1'b1;
        q.push_back(wb(1'b0, RESULT_SRC_MEM, 32'h0, 32'h200, 5'd4, 32'h5000));
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!stall_o) break;
            n++;
            step();
            dmem_req_ready_i = 1'b0;
        end
        chk("to_stall_cycles", 128'(n), 128'(4));
        step();
        valid_i = 1'b0;
        chk("to_buserr", 128'(bus_error_o), 128'(1'b1));
        check_wb("to_wb");
        dmem_rsp_valid_i = 1'b1;
        dmem_rdata_i     = 32'h5555_5555;
        @(negedge clk);
        chk("to_late_stall", 128'(stall_o), 128'(1'b0));
        step();
        dmem_rsp_valid_i = 1'b0;
        chk("to_late_wb",      128'(mem_wb_data_o), 128'(0));
        chk("to_buserr_end",   128'(bus_error_o), 128'(1'b0));

        // Reset in WAIT_RSP, then a stray response after release
        ex_mem_data_i = mk(1'b1, RESULT_SRC_ALU, 1'b0, 3'b000, 32'h77, 32'h0, 5'd6, 32'h6000);
        valid_i       = 1'b1;
        step();
        ex_mem_data_i    = mk(1'b1, RESULT_SRC_MEM, 1'b0, 3'b010, 32'h300, 32'h0, 5'd8, 32'h7000);
        dmem_req_ready_i = 1'b1;
        step();
        dmem_req_ready_i = 1'b0;
        @(negedge clk);
        chk("rw_wait_stall", 128'(stall_o), 128'(1'b1));
        #1;
        rst = 1'b1;
        #1;
        chk("rw_stall", 128'(stall_o), 128'(1'b0));
        chk("rw_req",   128'(dmem_req_valid_o), 128'(1'b0));
        chk("rw_wb",    128'(mem_wb_data_o), 128'(0));
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dmem_rsp_valid_i = 1'b1;
        dmem_rdata_i     = 32'hAAAA_AAAA;
        @(negedge clk);
        chk("rw_stray_stall", 128'(stall_o), 128'(1'b0));
        step();
        dmem_rsp_valid_i = 1'b0;
        chk("rw_stray_wb", 128'(mem_wb_data_o), 128'(0));

        // Stage is back in IDLE: an ALU op flows through unstalled
        ex_mem_data_i = mk(1'b1, RESULT_SRC_PC4, 1'b0, 3'b000, 32'h88, 32'h0, 5'd10, 32'h8000);
        valid_i       = 1'b1;
        q.push_back(wb(1'b1, RESULT_SRC_PC4, 32'h0, 32'h88, 5'd10, 32'h8000));
        @(negedge clk);
        chk("post_stall", 128'(stall_o), 128'(1'b0));
        step();
        valid_i = 1'b0;
        check_wb("post_wb");
        chk("sb_empty", 128'(q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
